// File: rtl/operand_entry.sv
// Keypad operand accumulator: builds a signed decimal magnitude key by key
// and hands it to the negation stage over a valid/ready handshake.
module operand_entry #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_neg,
  output logic             overflow,
  output logic [2:0]       digit_count
);

  localparam int unsigned CW = WIDTH + 4;
  localparam logic [CW-1:0] MAX_MAG = (CW'(1) << (WIDTH - 1)) - CW'(1);

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hD;

  typedef enum logic {ENTRY, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag;
  logic             neg;
  logic             ovf;
  logic [2:0]       cnt;
  logic [CW-1:0]    cand;

  // Widened candidate so mag*10+d can never wrap before the range check
  always_comb begin
    cand = CW'(mag) * CW'(10) + CW'(key_code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ENTRY;
      mag   <= '0;
      neg   <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (cand > MAX_MAG) begin
                ovf <= 1'b1;
              end else begin
                mag <= WIDTH'(cand);
                // Leading zeros leave the count alone
                if (cand != '0) cnt <= cnt + 3'd1;
              end
            end else begin
              case (key_code)
                KEY_SIGN: neg <= ~neg;
                KEY_BACK: begin
                  mag <= mag / WIDTH'(10);
                  ovf <= 1'b0;
                  if (cnt != '0) cnt <= cnt - 3'd1;
                end
                KEY_CLEAR: begin
                  mag <= '0;
                  neg <= 1'b0;
                  ovf <= 1'b0;
                  cnt <= '0;
                end
                KEY_ENTER: begin
                  // Negative zero is folded to positive zero at handoff
                  neg   <= neg && (mag != '0);
                  state <= HOLD;
                end
                default: ;
              endcase
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ENTRY;
            mag   <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

  assign key_ready   = (state == ENTRY);
  assign out_valid   = (state == HOLD);
  assign out_mag     = mag;
  assign out_neg     = neg;
  assign overflow    = ovf;
  assign digit_count = cnt;

endmodule

// File: doc/operand_entry.md
# operand_entry

Sequential keypad-operand accumulator for the calculator ALU, placed directly upstream of the sign-negation stage. It builds a signed decimal operand one key at a time: digits, sign toggle, backspace, clear and enter. On enter it hands the magnitude and sign flag downstream over a valid/ready handshake. The negation stage then forms the 16-bit two's-complement value from `out_mag` and `out_neg`.

## Interface
- `WIDTH`, default 16: operand width. Legal range 8..16. Maximum magnitude is `2^(WIDTH-1)-1` (32767 at 16).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `key_valid`  in  1  key event present.
- `key_code`  in  4  key code:
  - 0–9: digit.
  - 4'hA: sign toggle.
  - 4'hB: backspace.
  - 4'hC: clear.
  - 4'hD: enter.
  - 4'hE, 4'hF: no-op.
- `key_ready`  out  1  block can accept a key.
- `out_valid`  out  1  operand held for downstream.
- `out_ready`  in  1  downstream accepts operand.
- `out_mag`  out  WIDTH  unsigned magnitude; live accumulator value.
- `out_neg`  out  1  sign flag; 1 means negative.
- `overflow`  out  1  sticky: a digit was rejected since the last clear, backspace or handoff.
- `digit_count`  out  3  count of significant digits entered.

## Operation
- Two states:
  - ENTRY: `key_ready`=1, `out_valid`=0.
  - HOLD: `key_ready`=0, `out_valid`=1.
- `key_ready` and `out_valid` are decoded directly from the state register.
- A key is accepted on an edge where `key_valid && key_ready`. Keys presented in HOLD are ignored and not queued.
- Digit d:
  - Candidate = `mag*10 + d`, computed at WIDTH+4 bits.
  - If candidate > `2^(WIDTH-1)-1`: reject. Magnitude and count are unchanged; `overflow` is set.
  - Otherwise `mag` = candidate.
  - `digit_count` increments only if the candidate is nonzero (leading zeros are not counted).
- Sign toggle: `neg <= ~neg`. Magnitude is unaffected.
- Backspace: `mag <= mag/10` (integer division); `digit_count` decrements, saturating at 0; `overflow` clears.
- Clear: `mag`, `neg`, `overflow` and `digit_count` all go to 0.
- Enter: ENTRY→HOLD. The held sign is `neg && (mag != 0)`, so negative zero is never produced.
- 4'hE / 4'hF: the key is consumed with no state change.
- HOLD→ENTRY on the edge where `out_valid && out_ready`. On that edge `mag`, `neg`, `overflow` and `digit_count` all clear.
- In HOLD, `out_mag` and `out_neg` are frozen.

## Timing
- Reset (asynchronous, takes effect immediately without a clock edge):
  - State = ENTRY.
  - `out_mag`=0, `out_neg`=0, `overflow`=0, `digit_count`=0.
  - `out_valid`=0, `key_ready`=1.
- Key accepted at edge N: all outputs reflect the update in cycle N+1. Latency is 1 cycle.
- Enter accepted at edge N: `out_valid`=1 and `key_ready`=0 from cycle N+1.
- A transfer takes exactly one edge.
  - If `out_ready`=1 is already high when `out_valid` rises, transfer occurs at edge N+1. `out_valid` is then high for exactly one cycle.
  - From the cycle after transfer: `out_valid`=0, `key_ready`=1, accumulator cleared.
- `out_ready` is ignored in ENTRY.
- `out_mag` and `out_neg` must not change while `out_valid`=1.
- Reset asserted in HOLD: `out_valid` drops asynchronously and the operand is discarded.
- `key_valid` and `key_code` are sampled only on the edge. No combinational path from `key_*` to any output.

## Test plan
- Reset, then keys 1,2,3, enter, with `out_ready`=1:
  - `out_valid` high for one cycle starting the cycle after enter.
  - During that cycle `out_mag`=123, `out_neg`=0.
  - Next cycle `out_mag`=0, `key_ready`=1.
- Keys 3,2,7,6,7, enter: `out_mag`=32767. Then keys 3,2,7,6,8:
  - Last digit rejected: `out_mag`=3276, `digit_count`=4, `overflow`=1.
  - Backspace: `out_mag`=327, `digit_count`=3, `overflow`=0.
- Sign handling:
  - Keys 4,5, sign, enter: `out_mag`=45, `out_neg`=1.
  - Keys sign, sign, 9, enter: `out_neg`=0.
  - Keys sign, enter with magnitude 0: `out_neg`=0.
- Zeros and clear:
  - Keys 0,0,7: `digit_count`=1, `out_mag`=7.
  - Sign, then clear: `out_mag`=0, `out_neg`=0, `digit_count`=0.
- Held operand:
  - Enter 12, hold `out_ready`=0 for 5 cycles while driving digit 9 with `key_valid`=1.
  - `key_ready`=0 and `out_mag`=12 throughout.
  - Raise `out_ready`: transfer on the next edge, and digit 9 is never accumulated.
- Reset in HOLD: drop `rst_n` mid-cycle. `out_valid` and `out_mag` go to 0 before the next clock edge; `key_ready`=1.
